// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - execute-stage ALU with iterative multu/divu
//
// Purpose: single-cycle and/or/add/sub/slt/li with one registered cycle of
// latency, plus unsigned shift-add multiply and restoring divide that
// retire one bit per cycle into hi/lo. busy/done let the controller stall.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      latch operands and alucontrol this cycle
//   alucontrol 4-bit operation code
//   a, b       operands (WIDTH bits)
//   result     registered result
//   zero       result == 0
//   hi, lo     mult upper/lower half, or div remainder/quotient
//   busy       multi-cycle op in progress
//   done       one-cycle pulse when result (and hi/lo for mult/div) is valid
module iterative_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  // Multiply: opd = multiplicand, acc_lo = multiplier shifting out LSB-first,
  //           acc_hi = running upper half (one spare bit for the add carry).
  // Divide:   opd = divisor, acc_lo = dividend shifting into quotient,
  //           acc_hi = partial remainder.
  logic [WIDTH-1:0] opd;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH:0]   acc_hi;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH:0]   div_hi_next;
  logic [WIDTH-1:0] div_lo_next;
  logic [WIDTH-1:0] op_result;

  assign zero = (result == '0);

  always_comb begin
    mul_sum     = acc_hi + (acc_lo[0] ? {1'b0, opd} : '0);
    mul_hi_next = {1'b0, mul_sum[WIDTH:1]};
    mul_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};

    rem_shift   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    rem_ge      = (rem_shift >= {1'b0, opd});
    div_hi_next = rem_ge ? (rem_shift - {1'b0, opd}) : rem_shift;
    div_lo_next = {acc_lo[WIDTH-2:0], rem_ge};
  end

  // Undefined codes (including 1100/1101, handled by the FSM) yield zero.
  always_comb begin
    op_result = '0;
    case (alucontrol)
      4'b0000: op_result = a & b;
      4'b0001: op_result = a | b;
      4'b0010: op_result = a + b;
      4'b0110: op_result = a - b;
      4'b1010: op_result = a - b;
      4'b1011: op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0100: op_result = b;
      default: op_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      opd    <= '0;
      acc_lo <= '0;
      acc_hi <= '0;
      result <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (alucontrol == 4'b1100) begin
              state  <= MUL;
              cnt    <= '0;
              opd    <= a;
              acc_lo <= b;
              acc_hi <= '0;
              busy   <= 1'b1;
            end else if (alucontrol == 4'b1101) begin
              state  <= DIV;
              cnt    <= '0;
              opd    <= b;
              acc_lo <= a;
              acc_hi <= '0;
              busy   <= 1'b1;
            end else begin
              result <= op_result;
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_hi <= mul_hi_next;
          acc_lo <= mul_lo_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIN;
        end
        DIV: begin
          acc_hi <= div_hi_next;
          acc_lo <= div_lo_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIN;
        end
        FIN: begin
          hi     <= acc_hi[WIDTH-1:0];
          lo     <= acc_lo;
          result <= acc_lo;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
